// File: rtl/monitor_turno_ciclos_if.sv
// Bus bundle for monitor_turno_ciclos.
//   master: drives the cycle count, turn control and result ack; observes
//           the turn state, elapsed count, warning and result.
//   slave : the monitor itself (mirror directions).
interface monitor_turno_ciclos_if #(
    parameter int W = 8
);
    logic [W-1:0] ciclos_in;        // free-running cycle count
    logic         start;            // begin a turn (IDLE only)
    logic         stop;             // end the turn early (RUN only)
    logic [W-1:0] limite;           // cycle limit, 0 = unlimited
    logic         ack;              // result accepted
    logic [1:0]   estado;           // IDLE=0, RUN=1, DONE=2
    logic [W-1:0] transcurrido;     // elapsed cycles, registered
    logic         aviso;            // near-limit warning
    logic [W-1:0] resultado;        // final elapsed count
    logic         resultado_valid;  // result available
    logic         timeout;          // turn ended by limit or saturation
    logic [7:0]   turnos;           // completed turns, wraps

    modport master (
        output ciclos_in, start, stop, limite, ack,
        input  estado, transcurrido, aviso, resultado, resultado_valid,
               timeout, turnos
    );

    modport slave (
        input  ciclos_in, start, stop, limite, ack,
        output estado, transcurrido, aviso, resultado, resultado_valid,
               timeout, turnos
    );
endinterface

// File: rtl/monitor_turno_ciclos.sv
// Times one game turn against a programmable cycle limit.
// On start the free-running cycle count is snapshotted; elapsed time is the
// modulo-2^W difference to that snapshot, so counter wrap needs no handling.
// The turn ends on stop, on reaching the limit, or (no limit) on saturation;
// the result is then offered with a valid/ack handshake.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - monitor_turno_ciclos_if.slave (inputs ciclos_in, start, stop,
//           limite, ack; outputs estado, transcurrido, aviso, resultado,
//           resultado_valid, timeout, turnos)
module monitor_turno_ciclos #(
    parameter int W     = 8,
    parameter int AVISO = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    monitor_turno_ciclos_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } estado_t;

    estado_t      st, st_nxt;
    logic [W-1:0] base, lim;
    logic [W-1:0] elapsed;
    logic [W-1:0] transcurrido_q, resultado_q;
    logic         timeout_q;
    logic [7:0]   turnos_q;
    logic         lim_hit, sat_hit;
    logic [W:0]   aviso_sum;

    assign elapsed = bus.ciclos_in - base;
    assign lim_hit = (lim != '0) && (elapsed >= lim);
    // Without a limit the turn ends when the elapsed count would wrap.
    assign sat_hit = (lim == '0) && (elapsed == {W{1'b1}});
    // One extra bit so elapsed + margin never overflows.
    assign aviso_sum = {1'b0, elapsed} + (W+1)'(AVISO);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) st <= IDLE;
        else        st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    if (bus.start) st_nxt = RUN;
            RUN:     if (lim_hit || sat_hit || bus.stop) st_nxt = DONE;
            DONE:    if (bus.ack) st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.estado          = st;
        bus.aviso           = (st == RUN) && (lim != '0) &&
                              (aviso_sum >= {1'b0, lim});
        bus.resultado_valid = (st == DONE);
    end

    // Datapath; the limit/saturation branches come first so they win over
    // a simultaneous stop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base           <= '0;
            lim            <= '0;
            transcurrido_q <= '0;
            resultado_q    <= '0;
            timeout_q      <= 1'b0;
            turnos_q       <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (bus.start) begin
                        base      <= bus.ciclos_in;
                        lim       <= bus.limite;
                        timeout_q <= 1'b0;
                    end
                end
                RUN: begin
                    transcurrido_q <= elapsed;
                    if (lim_hit) begin
                        resultado_q <= lim;
                        timeout_q   <= 1'b1;
                    end else if (sat_hit) begin
                        resultado_q <= {W{1'b1}};
                        timeout_q   <= 1'b1;
                    end else if (bus.stop) begin
                        resultado_q <= elapsed;
                        timeout_q   <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.ack) turnos_q <= turnos_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.transcurrido = transcurrido_q;
    assign bus.resultado    = resultado_q;
    assign bus.timeout      = timeout_q;
    assign bus.turnos       = turnos_q;
endmodule

// File: tb/tb_monitor_turno_ciclos.sv
module tb_monitor_turno_ciclos;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    monitor_turno_ciclos_if #(.W(8)) b();
    monitor_turno_ciclos #(.W(8), .AVISO(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    int n_pass = 0;
    int n_tot  = 0;

    // Turn-level reference: phase 0 idle, 1 running, 2 result pending.
    int m_ph, m_base, m_lim, m_tr, m_res, m_to, m_turnos;

    typedef struct {
        logic       st, sp, ak;
        logic [7:0] c, lm;
        int         e_est, e_tr, e_res, e_val, e_to, e_turn;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic void m_reset();
        m_ph = 0; m_base = 0; m_lim = 0; m_tr = 0;
        m_res = 0; m_to = 0; m_turnos = 0;
    endfunction

    function automatic int m_elapsed();
        return (int'(b.ciclos_in) - m_base + 256) % 256;
    endfunction

    function automatic void m_edge();
        int el;
        el = m_elapsed();
        if (m_ph == 0) begin
            if (b.start) begin
                m_base = int'(b.ciclos_in); m_lim = int'(b.limite);
                m_to = 0; m_ph = 1;
            end
        end else if (m_ph == 1) begin
            m_tr = el;
            if (m_lim != 0 && el >= m_lim) begin
                m_res = m_lim; m_to = 1; m_ph = 2;
            end else if (m_lim == 0 && el == 255) begin
                m_res = 255; m_to = 1; m_ph = 2;
            end else if (b.stop) begin
                m_res = el; m_to = 0; m_ph = 2;
            end
        end else begin
            if (b.ack) begin
                m_turnos = (m_turnos + 1) % 256; m_ph = 0;
            end
        end
    endfunction

    task automatic check_all();
        int el;
        el = m_elapsed();
        chk("estado", int'(b.estado), m_ph);
        chk("transcurrido", int'(b.transcurrido), m_tr);
        chk("aviso", int'(b.aviso), int'(m_ph == 1 && m_lim != 0 && el + 3 >= m_lim));
        chk("resultado", int'(b.resultado), m_res);
        chk("resultado_valid", int'(b.resultado_valid), int'(m_ph == 2));
        chk("timeout", int'(b.timeout), m_to);
        chk("turnos", int'(b.turnos), m_turnos);
    endtask

    task automatic cyc(input logic st, input logic sp, input logic ak,
                       input logic [7:0] c, input logic [7:0] lm);
        b.start = st; b.stop = sp; b.ack = ak;
        b.ciclos_in = c; b.limite = lm;
        @(posedge clk);
        m_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic [7:0] c;
        b.start = 0; b.stop = 0; b.ack = 0; b.ciclos_in = 0; b.limite = 0;
        m_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_estado", int'(b.estado), 0);
        chk("rst_valid", int'(b.resultado_valid), 0);
        chk("rst_turnos", int'(b.turnos), 0);
        @(negedge clk) reset = 1'b1;

        // stop/ack ignored in IDLE
        for (int i = 0; i < 5; i++) cyc(1'b0, i % 2 == 0, i % 2 == 1, 8'd7, 8'd9);
        chk("idle_estado", int'(b.estado), 0);
        chk("idle_resultado", int'(b.resultado), 0);
        chk("idle_turnos", int'(b.turnos), 0);

        // early stop, table driven
        tv.push_back('{1'b1, 1'b0, 1'b0, 8'd20, 8'd50, 1, 0, 0, 0, 0, 0});
        for (int k = 21; k <= 31; k++)
            tv.push_back('{1'b0, 1'b0, 1'b0, 8'(k), 8'd50, 1, k - 20, 0, 0, 0, 0});
        tv.push_back('{1'b0, 1'b1, 1'b0, 8'd32, 8'd50, 2, 12, 12, 1, 0, 0});
        tv.push_back('{1'b1, 1'b0, 1'b0, 8'd33, 8'd50, 2, 12, 12, 1, 0, 0});
        tv.push_back('{1'b0, 1'b0, 1'b1, 8'd34, 8'd50, 0, 12, 12, 0, 0, 1});
        foreach (tv[i]) begin
            cyc(tv[i].st, tv[i].sp, tv[i].ak, tv[i].c, tv[i].lm);
            chk("tv_estado", int'(b.estado), tv[i].e_est);
            chk("tv_transcurrido", int'(b.transcurrido), tv[i].e_tr);
            chk("tv_resultado", int'(b.resultado), tv[i].e_res);
            chk("tv_valid", int'(b.resultado_valid), tv[i].e_val);
            chk("tv_timeout", int'(b.timeout), tv[i].e_to);
            chk("tv_turnos", int'(b.turnos), tv[i].e_turn);
        end

        // limit timeout with warning
        cyc(1'b1, 1'b0, 1'b0, 8'd100, 8'd10);
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 8'(100 + k), 8'd10);
            if (k == 6) chk("to_aviso_e6", int'(b.aviso), 0);
            if (k == 7) chk("to_aviso_e7", int'(b.aviso), 1);
            if (k == 9) chk("to_estado_e9", int'(b.estado), 1);
        end
        chk("to_estado", int'(b.estado), 2);
        chk("to_resultado", int'(b.resultado), 10);
        chk("to_timeout", int'(b.timeout), 1);
        cyc(1'b0, 1'b0, 1'b1, 8'd111, 8'd10);
        chk("to_turnos", int'(b.turnos), 2);

        // wrap-around of the cycle counter
        cyc(1'b1, 1'b0, 1'b0, 8'd250, 8'd0);
        for (int k = 1; k <= 9; k++) cyc(1'b0, 1'b0, 1'b0, 8'(250 + k), 8'd0);
        cyc(1'b0, 1'b1, 1'b0, 8'd4, 8'd0);
        chk("wrap_resultado", int'(b.resultado), 10);
        chk("wrap_timeout", int'(b.timeout), 0);
        cyc(1'b0, 1'b0, 1'b1, 8'd5, 8'd0);

        // saturation with no limit
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        for (int k = 1; k <= 254; k++) cyc(1'b0, 1'b0, 1'b0, 8'(k), 8'd0);
        chk("sat_estado_254", int'(b.estado), 1);
        cyc(1'b0, 1'b0, 1'b0, 8'd255, 8'd0);
        chk("sat_estado", int'(b.estado), 2);
        chk("sat_resultado", int'(b.resultado), 255);
        chk("sat_timeout", int'(b.timeout), 1);
        cyc(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);

        // stop on the timeout cycle, then start+ack in DONE
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd5);
        for (int k = 1; k <= 4; k++) cyc(1'b0, 1'b0, 1'b0, 8'(k), 8'd5);
        cyc(1'b0, 1'b1, 1'b0, 8'd5, 8'd5);
        chk("col_timeout", int'(b.timeout), 1);
        chk("col_resultado", int'(b.resultado), 5);
        cyc(1'b1, 1'b0, 1'b0, 8'd6, 8'd5);
        chk("col_start_done", int'(b.estado), 2);
        cyc(1'b1, 1'b0, 1'b1, 8'd7, 8'd5);
        chk("col_start_ack", int'(b.estado), 0);
        cyc(1'b0, 1'b0, 1'b0, 8'd8, 8'd5);
        chk("col_no_turn", int'(b.estado), 0);
        chk("col_turnos", int'(b.turnos), 5);

        // asynchronous reset mid-turn
        cyc(1'b1, 1'b0, 1'b0, 8'd10, 8'd20);
        cyc(1'b0, 1'b0, 1'b0, 8'd11, 8'd20);
        cyc(1'b0, 1'b0, 1'b0, 8'd12, 8'd20);
        #2 reset = 1'b0;
        #1;
        m_reset();
        chk("mrst_estado", int'(b.estado), 0);
        chk("mrst_turnos", int'(b.turnos), 0);
        check_all();
        @(negedge clk) reset = 1'b1;

        // randomized traffic against the model
        c = 8'($urandom);
        for (int n = 0; n < 3000; n++) begin
            c = ($urandom % 8 == 0) ? 8'($urandom) : c + 8'd1;
            cyc($urandom % 4 == 0, $urandom % 16 == 0, $urandom % 3 == 0, c,
                ($urandom % 4 == 0) ? 8'd0 : 8'($urandom_range(1, 40)));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
